// File: rtl/ema_inverse_filter.sv
// ---------------------------------------------------------------------------
// ema_inverse_filter
//   Inverse of the beta=3/4 EMA stage y[n] = floor(x[n]/4) + floor(3*y[n-1]/4).
//   Rebuilds an input estimate x_hat = 4*(y[n] - floor(3*y[n-1]/4)) and clamps it
//   into DATA_W unsigned bits. The two low bits of x dropped by the forward
//   alpha truncation cannot be recovered, so x_hat is always a multiple of 4.
//   Valid/ready streaming on both sides, with one registered output stage.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous: drop history, go to IDLE, zero counters
//   in_valid   y sample valid
//   in_ready   block can take a y sample this cycle
//   in_data    EMA output sample y[n]
//   out_valid  x_hat valid
//   out_ready  sink accepts x_hat
//   out_data   reconstructed (saturated) x_hat
//   out_sat    x_hat was clamped (qualified by out_valid)
//   samp_cnt   x_hat words handed off, wraps
//   sat_cnt    clamped words handed off, sticks at all-ones
// ---------------------------------------------------------------------------
module ema_inverse_filter #(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 16,
  parameter int PRIME_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic [CNT_W-1:0]  samp_cnt,
  output logic [CNT_W-1:0]  sat_cnt
);

  localparam int XW = DATA_W + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [DATA_W-1:0]  y_prev;
  logic [DATA_W-1:0]  y_eff;
  logic               accept;
  logic               emit;
  logic               handshake;
  logic signed [XW-1:0] y_ext;
  logic signed [XW-1:0] beta;
  logic signed [XW-1:0] diff;
  logic signed [XW-1:0] x_raw;
  logic [DATA_W-1:0]  x_sat;
  logic               x_is_sat;

  // The input side only stalls when a word is parked in the output register
  // and the sink is refusing it; a word leaving this cycle frees the slot.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // Next state and whether this accept produces an output word. With
  // PRIME_FIRST set, the very first sample after reset/clear only seeds the
  // history. PRIME is a one-cycle marker for that event; it behaves like RUN.
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (PRIME_FIRST != 0) begin
            state_next = PRIME;
          end else begin
            emit       = 1'b1;
            state_next = RUN;
          end
        end
      end
      PRIME: begin
        emit       = accept;
        state_next = RUN;
      end
      RUN: begin
        emit = accept;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath in DATA_W+3 signed bits throughout. The beta term never exceeds
  // 3/4 of full scale, and the difference times 4 spans -4*191..4*255, so
  // nothing wraps before the clamp. Numerically this equals the narrower
  // DATA_W+2 beta / DATA_W+1 diff formulation.
  always_comb begin
    y_eff    = (state == IDLE) ? '0 : y_prev;
    y_ext    = {3'b000, y_eff};
    beta     = (y_ext + (y_ext <<< 1)) >>> 2;
    diff     = $signed({3'b000, in_data}) - beta;
    x_raw    = diff <<< 2;
    x_sat    = x_raw[DATA_W-1:0];
    x_is_sat = 1'b0;
    if (x_raw[XW-1]) begin
      x_sat    = '0;
      x_is_sat = 1'b1;
    end else if (x_raw[XW-2:DATA_W] != '0) begin
      x_sat    = '1;
      x_is_sat = 1'b1;
    end
  end

  // State and history. Clear wins over a same-cycle accept so the history is
  // guaranteed empty afterwards; every other accept, priming or not, updates
  // the history with the new y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      y_prev <= '0;
    end else if (clear) begin
      state  <= IDLE;
      y_prev <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        y_prev <= in_data;
      end
    end
  end

  // Output register. A new word can replace a departing one in the same
  // cycle, so back-to-back samples stream with no bubble; while stalled the
  // data and sat flag are left untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= x_sat;
      out_sat   <= x_is_sat;
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

  // Counters advance on output handshakes only; the saturation counter
  // sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt <= '0;
      sat_cnt  <= '0;
    end else if (clear) begin
      samp_cnt <= '0;
      sat_cnt  <= '0;
    end else if (handshake) begin
      samp_cnt <= samp_cnt + 1'b1;
      if (out_sat && (sat_cnt != '1)) begin
        sat_cnt <= sat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ema_inverse_filter.sv
// ---------------------------------------------------------------------------
// tb_ema_inverse_filter
//   Directed bench for ema_inverse_filter. dut0 runs with PRIME_FIRST=0 and
//   carries most scenarios; dut1 runs with PRIME_FIRST=1 for the priming case.
//   Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ema_inverse_filter;

  logic        clk;
  logic        rst_n;

  logic        clear0;
  logic        in_valid0;
  logic        in_ready0;
  logic [7:0]  in_data0;
  logic        out_valid0;
  logic        out_ready0;
  logic [7:0]  out_data0;
  logic        out_sat0;
  logic [15:0] samp_cnt0;
  logic [15:0] sat_cnt0;

  logic        clear1;
  logic        in_valid1;
  logic        in_ready1;
  logic [7:0]  in_data1;
  logic        out_valid1;
  logic        out_ready1;
  logic [7:0]  out_data1;
  logic        out_sat1;
  logic [15:0] samp_cnt1;
  logic [15:0] sat_cnt1;

  int checks;
  int errors;

  ema_inverse_filter #(.DATA_W(8), .CNT_W(16), .PRIME_FIRST(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear0),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .in_data   (in_data0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .out_data  (out_data0),
    .out_sat   (out_sat0),
    .samp_cnt  (samp_cnt0),
    .sat_cnt   (sat_cnt0)
  );

  ema_inverse_filter #(.DATA_W(8), .CNT_W(16), .PRIME_FIRST(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_data  (out_data1),
    .out_sat   (out_sat1),
    .samp_cnt  (samp_cnt1),
    .sat_cnt   (sat_cnt1)
  );

  // Free-running 10 time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of dut0 inputs, then move to the next sampling point.
  task automatic applyStimulus(input logic valid, input logic [7:0] data,
                               input logic rdy, input logic clr);
    in_valid0  = valid;
    in_data0   = data;
    out_ready0 = rdy;
    clear0     = clr;
    @(negedge clk);
  endtask

  // Checks the full output word of dut0 in one call.
  task automatic checkWord(input string tag, input logic v, input logic [7:0] d,
                           input logic s);
    checkOutput({tag, ".valid"}, {31'd0, out_valid0}, {31'd0, v});
    checkOutput({tag, ".data"},  {24'd0, out_data0},  {24'd0, d});
    checkOutput({tag, ".sat"},   {31'd0, out_sat0},   {31'd0, s});
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    clear0     = 1'b0;
    in_valid0  = 1'b0;
    in_data0   = 8'd0;
    out_ready0 = 1'b1;
    clear1     = 1'b0;
    in_valid1  = 1'b0;
    in_data1   = 8'd0;
    out_ready1 = 1'b1;
    repeat (2) @(negedge clk);

    checkWord("reset", 1'b0, 8'd0, 1'b0);
    checkOutput("reset.samp_cnt", {16'd0, samp_cnt0}, 32'd0);
    checkOutput("reset.sat_cnt",  {16'd0, sat_cnt0},  32'd0);
    checkOutput("reset.in_ready", {31'd0, in_ready0}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: y=10 -> 40, then y=20 -> b=7, d=13 -> 52, back to back.
    applyStimulus(1'b1, 8'd10, 1'b1, 1'b0);
    checkWord("t1.first", 1'b1, 8'd40, 1'b0);
    applyStimulus(1'b1, 8'd20, 1'b1, 1'b0);
    checkWord("t1.second", 1'b1, 8'd52, 1'b0);
    checkOutput("t1.samp_cnt_mid", {16'd0, samp_cnt0}, 32'd1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("t1.drop_valid", {31'd0, out_valid0}, 32'd0);
    checkOutput("t1.samp_cnt", {16'd0, samp_cnt0}, 32'd2);

    // T2: clear history, y=100 -> 400 clamps to 255.
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    checkOutput("t2.clear_cnt", {16'd0, samp_cnt0}, 32'd0);
    applyStimulus(1'b1, 8'd100, 1'b1, 1'b0);
    checkWord("t2.high", 1'b1, 8'd255, 1'b1);

    // T3: y=200 (b=75, 500 -> 255 sat), then y=100 (b=150, d=-50 -> 0 sat).
    applyStimulus(1'b1, 8'd200, 1'b1, 1'b0);
    checkOutput("t2.sat_cnt", {16'd0, sat_cnt0}, 32'd1);
    checkWord("t3.high", 1'b1, 8'd255, 1'b1);
    applyStimulus(1'b1, 8'd100, 1'b1, 1'b0);
    checkWord("t3.low", 1'b1, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("t3.samp_cnt", {16'd0, samp_cnt0}, 32'd3);
    checkOutput("t3.sat_cnt",  {16'd0, sat_cnt0},  32'd3);

    // T4: y=100 with prev 100 -> b=75, d=25 -> 100; sink stalls 5 cycles
    // while a y=50 is offered and must not be taken.
    applyStimulus(1'b1, 8'd100, 1'b0, 1'b0);
    checkWord("t4.first", 1'b1, 8'd100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'd50, 1'b0, 1'b0);
      checkWord("t4.hold", 1'b1, 8'd100, 1'b0);
      checkOutput("t4.in_ready", {31'd0, in_ready0}, 32'd0);
    end
    checkOutput("t4.samp_cnt_stall", {16'd0, samp_cnt0}, 32'd3);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("t4.release_valid", {31'd0, out_valid0}, 32'd0);
    checkOutput("t4.release_cnt", {16'd0, samp_cnt0}, 32'd4);
    applyStimulus(1'b1, 8'd100, 1'b1, 1'b0);
    checkWord("t4.history", 1'b1, 8'd100, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("t4.samp_cnt", {16'd0, samp_cnt0}, 32'd5);

    // T6: y=40 pending (b=75, d=-35 -> 0 sat), then clear with a competing
    // accept; afterwards y=8 must see empty history -> 32.
    applyStimulus(1'b1, 8'd40, 1'b0, 1'b0);
    checkWord("t6.pending", 1'b1, 8'd0, 1'b1);
    applyStimulus(1'b1, 8'd77, 1'b0, 1'b1);
    checkOutput("t6.clear_valid", {31'd0, out_valid0}, 32'd0);
    checkOutput("t6.clear_samp",  {16'd0, samp_cnt0}, 32'd0);
    checkOutput("t6.clear_sat",   {16'd0, sat_cnt0},  32'd0);
    checkOutput("t6.in_ready",    {31'd0, in_ready0}, 32'd1);
    applyStimulus(1'b1, 8'd8, 1'b1, 1'b0);
    checkWord("t6.after_clear", 1'b1, 8'd32, 1'b0);

    // Async reset mid-burst: y=50 (b=6, d=44 -> 176) then rst_n drops.
    applyStimulus(1'b1, 8'd50, 1'b1, 1'b0);
    checkWord("t6.burst", 1'b1, 8'd176, 1'b0);
    checkOutput("t6.burst_cnt", {16'd0, samp_cnt0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkWord("t6.async", 1'b0, 8'd0, 1'b0);
    checkOutput("t6.async_samp", {16'd0, samp_cnt0}, 32'd0);
    in_valid0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 8'd8, 1'b1, 1'b0);
    checkWord("t6.after_reset", 1'b1, 8'd32, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

    // T5: PRIME_FIRST=1, y=80 only primes; second y=80 -> b=60, d=20 -> 80.
    in_valid1 = 1'b1;
    in_data1  = 8'd80;
    @(negedge clk);
    checkOutput("t5.prime_valid", {31'd0, out_valid1}, 32'd0);
    @(negedge clk);
    checkOutput("t5.valid", {31'd0, out_valid1}, 32'd1);
    checkOutput("t5.data",  {24'd0, out_data1},  32'd80);
    checkOutput("t5.sat",   {31'd0, out_sat1},   32'd0);
    in_valid1 = 1'b0;
    @(negedge clk);
    checkOutput("t5.samp_cnt", {16'd0, samp_cnt1}, 32'd1);
    checkOutput("t5.drop_valid", {31'd0, out_valid1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
